gpr_scoreboard: RTL and testbench

General-purpose register file with write-reservation scoreboard for the four-stage core. It serves the decode stage's read and reservation requests (ID<->RF) and accepts register updates from the write-back stage (WB-->RF). Each destination register is marked busy from decode until write-back, so decode can detect RAW hazards. Sixteen 16-bit registers, two combinational read ports, one synchronous write port.

---
 rtl/gpr_scoreboard.sv | 84 ++++++++
 tb/tb_gpr_scoreboard.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/gpr_scoreboard.sv
// gpr_scoreboard: 16 x 16-bit general-purpose register file with a
// write-reservation (busy) scoreboard for RAW hazard detection in decode.
// Two combinational read ports, one synchronous write-back port.
// Optional feature macro: GPR_WB_BYPASS_EN forwards write-back data and
// clears the busy bit combinationally in the write-back cycle.
module gpr_scoreboard #(
    parameter int DW   = 16,
    parameter int NREG = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [$clog2(NREG)-1:0]  r0_num_i,
    input  logic [$clog2(NREG)-1:0]  r1_num_i,
    output logic [DW-1:0]            r0_data_o,
    output logic [DW-1:0]            r1_data_o,
    input  logic                     w_reserve_i,
    input  logic [$clog2(NREG)-1:0]  w_reserve_num_i,
    output logic [NREG-1:0]          reserved_o,
    input  logic                     wb_i,
    input  logic [$clog2(NREG)-1:0]  wbr_num_i,
    input  logic [DW-1:0]            wb_data_i
);

    logic [DW-1:0]   regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;

    // Next busy map: write-back clears first, so a same-edge reserve of the
    // same register wins (a new producer is already in flight).
    always_comb begin
        busy_next = busy;
        if (wb_i) begin
            busy_next[wbr_num_i] = 1'b0;
        end
        if (w_reserve_i) begin
            busy_next[w_reserve_num_i] = 1'b1;
        end
    end

    // Register file and scoreboard update; reset clears everything and
    // overrides any write-back or reserve sampled on the same edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            if (wb_i) begin
                regs[wbr_num_i] <= wb_data_i;
            end
            busy <= busy_next;
        end
    end

`ifdef GPR_WB_BYPASS_EN
    // Read ports with write-back forwarding; busy bit of the register being
    // written reads clear unless it is re-reserved on this same edge.
    always_comb begin
        r0_data_o  = regs[r0_num_i];
        r1_data_o  = regs[r1_num_i];
        reserved_o = busy;
        if (wb_i) begin
            if (r0_num_i == wbr_num_i) begin
                r0_data_o = wb_data_i;
            end
            if (r1_num_i == wbr_num_i) begin
                r1_data_o = wb_data_i;
            end
            if (!(w_reserve_i && (w_reserve_num_i == wbr_num_i))) begin
                reserved_o[wbr_num_i] = 1'b0;
            end
        end
    end
`else
    // Read ports return the stored value; busy map comes straight from flops.
    always_comb begin
        r0_data_o  = regs[r0_num_i];
        r1_data_o  = regs[r1_num_i];
        reserved_o = busy;
    end
`endif

endmodule

// File: tb/tb_gpr_scoreboard.sv
// Testbench for gpr_scoreboard: directed steps from the test plan followed
// by randomized traffic checked against a behavioural register/busy model.
module tb_gpr_scoreboard;

    logic        clk;
    logic        rst;
    logic [3:0]  r0_num;
    logic [3:0]  r1_num;
    logic [15:0] r0_data;
    logic [15:0] r1_data;
    logic        w_reserve;
    logic [3:0]  w_reserve_num;
    logic [15:0] reserved;
    logic        wb;
    logic [3:0]  wbr_num;
    logic [15:0] wb_data;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    logic [15:0] m_regs [16];
    logic        m_busy [16];

    gpr_scoreboard #(.DW(16), .NREG(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .r0_num_i        (r0_num),
        .r1_num_i        (r1_num),
        .r0_data_o       (r0_data),
        .r1_data_o       (r1_data),
        .w_reserve_i     (w_reserve),
        .w_reserve_num_i (w_reserve_num),
        .reserved_o      (reserved),
        .wb_i            (wb),
        .wbr_num_i       (wbr_num),
        .wb_data_i       (wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_read(input logic [3:0] n);
        logic [15:0] v;
        v = m_regs[n];
`ifdef GPR_WB_BYPASS_EN
        if (wb && n == wbr_num) v = wb_data;
`endif
        return v;
    endfunction

    function automatic logic [15:0] exp_reserved();
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = m_busy[i];
`ifdef GPR_WB_BYPASS_EN
        if (wb && !(w_reserve && w_reserve_num == wbr_num)) v[wbr_num] = 1'b0;
`endif
        return v;
    endfunction

    // Apply inputs for one cycle, compare outputs with the model before the
    // edge, then advance the model by the spec's edge rules.
    task automatic step(input logic rst_v, input logic wb_v, input logic [3:0] wbn,
                        input logic [15:0] wbd, input logic res_v, input logic [3:0] resn,
                        input logic [3:0] n0, input logic [3:0] n1, input logic chk);
        rst = rst_v; wb = wb_v; wbr_num = wbn; wb_data = wbd;
        w_reserve = res_v; w_reserve_num = resn; r0_num = n0; r1_num = n1;
        #1;
        if (chk) begin
            check("model_r0", r0_data, exp_read(n0));
            check("model_r1", r1_data, exp_read(n1));
            check("model_reserved", reserved, exp_reserved());
        end
        @(posedge clk);
        if (!rst_v) begin
            for (int i = 0; i < 16; i++) begin
                m_regs[i] = 16'h0000;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (wb_v) begin
                m_regs[wbn] = wbd;
                m_busy[wbn] = 1'b0;
            end
            if (res_v) m_busy[resn] = 1'b1;
        end
        #1;
    endtask

    task automatic idle(input logic [3:0] n0, input logic [3:0] n1);
        rst = 1'b1; wb = 1'b0; w_reserve = 1'b0;
        r0_num = n0; r1_num = n1;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            m_regs[i] = 16'hxxxx;
            m_busy[i] = 1'bx;
        end
        rst = 1'b0; wb = 1'b0; wbr_num = 4'd0; wb_data = 16'h0;
        w_reserve = 1'b0; w_reserve_num = 4'd0; r0_num = 4'd0; r1_num = 4'd0;

        // Reset held 2 edges with a write-back pending
        step(1'b0, 1'b1, 4'd3, 16'hBEEF, 1'b0, 4'd0, 4'd3, 4'd3, 1'b0);
        step(1'b0, 1'b1, 4'd3, 16'hBEEF, 1'b0, 4'd0, 4'd3, 4'd3, 1'b0);
        idle(4'd3, 4'd7);
        check("reset_reserved", reserved, 16'h0000);
        check("reset_r3", r0_data, 16'h0000);
        check("reset_r7", r1_data, 16'h0000);

        // Reserve r5, then write it back three edges later
        step(1'b1, 1'b0, 4'd0, 16'h0, 1'b1, 4'd5, 4'd5, 4'd0, 1'b1);
        idle(4'd5, 4'd0);
        check("reserve_r5", reserved, 16'h0020);
        step(1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd5, 4'd0, 1'b1);
        step(1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd5, 4'd0, 1'b1);
        step(1'b1, 1'b1, 4'd5, 16'h1234, 1'b0, 4'd0, 4'd5, 4'd0, 1'b1);
        idle(4'd5, 4'd5);
        check("wb_r5_reserved", reserved, 16'h0000);
        check("wb_r5_data", r0_data, 16'h1234);

        // Simultaneous reserve and write-back on busy r7
        step(1'b1, 1'b0, 4'd0, 16'h0, 1'b1, 4'd7, 4'd7, 4'd7, 1'b1);
        step(1'b1, 1'b1, 4'd7, 16'h00AA, 1'b1, 4'd7, 4'd7, 4'd0, 1'b1);
        idle(4'd7, 4'd0);
        check("simul_r7_data", r0_data, 16'h00AA);
        check("simul_r7_busy", {15'h0, reserved[7]}, 16'h0001);
        step(1'b1, 1'b1, 4'd7, 16'h00AB, 1'b0, 4'd0, 4'd7, 4'd0, 1'b1);

        // Dual read
        step(1'b1, 1'b1, 4'd2, 16'h0002, 1'b0, 4'd0, 4'd2, 4'd9, 1'b1);
        step(1'b1, 1'b1, 4'd9, 16'h0009, 1'b0, 4'd0, 4'd2, 4'd9, 1'b1);
        idle(4'd2, 4'd9);
        check("dual_r2", r0_data, 16'h0002);
        check("dual_r9", r1_data, 16'h0009);
        idle(4'd9, 4'd9);
        check("same_r9_p0", r0_data, 16'h0009);
        check("same_r9_p1", r1_data, 16'h0009);

        // Bypass behaviour: r4 = 0x1111 and busy, then written with 0x2222
        step(1'b1, 1'b1, 4'd4, 16'h1111, 1'b1, 4'd4, 4'd4, 4'd4, 1'b1);
        rst = 1'b1; wb = 1'b1; wbr_num = 4'd4; wb_data = 16'h2222;
        w_reserve = 1'b0; r0_num = 4'd4; r1_num = 4'd4;
        #1;
`ifdef GPR_WB_BYPASS_EN
        check("bypass_r4_data", r0_data, 16'h2222);
        check("bypass_r4_busy", {15'h0, reserved[4]}, 16'h0000);
`else
        check("nobypass_r4_data", r0_data, 16'h1111);
        check("nobypass_r4_busy", {15'h0, reserved[4]}, 16'h0001);
`endif
        step(1'b1, 1'b1, 4'd4, 16'h2222, 1'b0, 4'd0, 4'd4, 4'd4, 1'b1);
        idle(4'd4, 4'd4);
        check("after_wb_r4_data", r0_data, 16'h2222);
        check("after_wb_r4_busy", {15'h0, reserved[4]}, 16'h0000);

        // Reset mid-operation discards reservations; later write applies
        step(1'b1, 1'b0, 4'd0, 16'h0, 1'b1, 4'd1, 4'd1, 4'd2, 1'b1);
        step(1'b1, 1'b0, 4'd0, 16'h0, 1'b1, 4'd2, 4'd1, 4'd2, 1'b1);
        step(1'b1, 1'b0, 4'd0, 16'h0, 1'b1, 4'd3, 4'd1, 4'd2, 1'b1);
        idle(4'd1, 4'd2);
        check("pre_reset_reserved", reserved, 16'h000E);
        step(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd1, 4'd2, 1'b0);
        idle(4'd2, 4'd4);
        check("midreset_reserved", reserved, 16'h0000);
        check("midreset_r4_cleared", r1_data, 16'h0000);
        step(1'b1, 1'b1, 4'd2, 16'h0F0F, 1'b0, 4'd0, 4'd2, 4'd2, 1'b1);
        idle(4'd2, 4'd2);
        check("late_wb_reserved", reserved, 16'h0000);
        check("late_wb_r2", r0_data, 16'h0F0F);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 39) != 0),
                 ($urandom_range(0, 2) != 0), 4'($urandom_range(0, 15)), 16'($urandom),
                 ($urandom_range(0, 1) != 0), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
